// File: rtl/logic_gate_lab_if.sv
// Board-side signal bundle for logic_gate_lab: raw switches/button in, LED levels out.
interface logic_gate_lab_if #(
    parameter int unsigned N_IN = 2
);
    logic [N_IN-1:0] i_p_sw;
    logic            i_p_btn_mode;
    logic [N_IN-1:0] o_p_led_in;
    logic            o_p_led_gate;
    logic [2:0]      o_p_led_mode;

    // Master drives the board inputs and watches the LEDs.
    modport master (
        output i_p_sw,
        output i_p_btn_mode,
        input  o_p_led_in,
        input  o_p_led_gate,
        input  o_p_led_mode
    );

    modport slave (
        input  i_p_sw,
        input  i_p_btn_mode,
        output o_p_led_in,
        output o_p_led_gate,
        output o_p_led_mode
    );
endinterface

// File: rtl/logic_gate_lab.sv
// Debounced multi-function gate demonstrator: N_IN switches reduced through a
// button-selected gate (AND/OR/XOR/NAND/NOR/XNOR), shown on registered LEDs.
module logic_gate_lab #(
    parameter int unsigned N_IN            = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input logic              I_P_CLK,
    input logic              I_P_RST,
    logic_gate_lab_if.slave  bus
);

    localparam int unsigned NumRaw = N_IN + 1;
    localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ModeAnd  = 3'd0,
        ModeOr   = 3'd1,
        ModeXor  = 3'd2,
        ModeNand = 3'd3,
        ModeNor  = 3'd4,
        ModeXnor = 3'd5
    } mode_e;

    // Bit N_IN of the raw/sync/debounced vectors carries the mode button.
    logic [NumRaw-1:0] meta_q, meta_d;
    logic [NumRaw-1:0] sync_q, sync_d;
    logic [NumRaw-1:0] db_q, db_d;
    logic [CntW-1:0]   cnt_q [NumRaw];
    logic [CntW-1:0]   cnt_d [NumRaw];
    logic              btn_prev_q, btn_prev_d;
    logic              pulse_q, pulse_d;
    logic              gate_q, gate_d;
    mode_e             mode_q, mode_d;

    logic [N_IN-1:0]   sw_db;
    logic              btn_db;

    assign sw_db  = db_q[N_IN-1:0];
    assign btn_db = db_q[N_IN];

    always_comb begin
        meta_d = {bus.i_p_btn_mode, bus.i_p_sw};
        sync_d = meta_q;
        db_d   = db_q;
        for (int unsigned i = 0; i < NumRaw; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    db_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_comb begin
        btn_prev_d = btn_db;
        pulse_d    = btn_db & ~btn_prev_q;
        mode_d     = mode_q;
        if (pulse_q) begin
            // Out-of-range codes fall back to AND on the next advance.
            mode_d = (mode_q >= ModeXnor) ? ModeAnd : mode_e'(mode_q + 3'd1);
        end
    end

    always_comb begin
        gate_d = &sw_db;
        case (mode_q)
            ModeAnd:  gate_d = &sw_db;
            ModeOr:   gate_d = |sw_db;
            ModeXor:  gate_d = ^sw_db;
            ModeNand: gate_d = ~&sw_db;
            ModeNor:  gate_d = ~|sw_db;
            ModeXnor: gate_d = ~^sw_db;
            default:  gate_d = &sw_db;
        endcase
    end

    always_ff @(posedge I_P_CLK) begin
        if (I_P_RST) begin
            meta_q     <= '0;
            sync_q     <= '0;
            db_q       <= '0;
            for (int unsigned i = 0; i < NumRaw; i++) begin
                cnt_q[i] <= '0;
            end
            btn_prev_q <= 1'b0;
            pulse_q    <= 1'b0;
            gate_q     <= 1'b0;
            mode_q     <= ModeAnd;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            db_q       <= db_d;
            for (int unsigned i = 0; i < NumRaw; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            btn_prev_q <= btn_prev_d;
            pulse_q    <= pulse_d;
            gate_q     <= gate_d;
            mode_q     <= mode_d;
        end
    end

    assign bus.o_p_led_in   = sw_db;
    assign bus.o_p_led_gate = gate_q;
    assign bus.o_p_led_mode = mode_q;

endmodule

// File: tb/tb_logic_gate_lab.sv
// Bench for logic_gate_lab: directed scenarios plus random stimulus on an N_IN=2
// and an N_IN=4 instance, both compared every cycle against a sample-window model.
module tb_logic_gate_lab;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic_gate_lab_if #(.N_IN(2)) bus2 ();
    logic_gate_lab_if #(.N_IN(4)) bus4 ();

    assign bus2.i_p_btn_mode = btn;
    assign bus4.i_p_btn_mode = btn;

    logic_gate_lab #(.N_IN(2), .DEBOUNCE_CYCLES(D)) u_dut2 (
        .I_P_CLK (clk),
        .I_P_RST (rst),
        .bus     (bus2)
    );

    logic_gate_lab #(.N_IN(4), .DEBOUNCE_CYCLES(D)) u_dut4 (
        .I_P_CLK (clk),
        .I_P_RST (rst),
        .bus     (bus4)
    );

    // Model state: index 0 = N_IN=2 instance, 1 = N_IN=4 instance.
    // m_hist[d][k] is the raw input vector sampled k+1 edges ago.
    logic [4:0] m_hist [2][D+2];
    logic [4:0] m_db   [2];
    logic [2:0] m_mode [2];
    logic       m_pulse[2];
    logic       m_prev [2];
    logic       m_gate [2];

    function automatic logic gate_ref(logic [3:0] sw, int n, logic [2:0] mode);
        int   ones;
        logic r;
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(sw[i]);
        case (mode)
            3'd1, 3'd4: r = (ones > 0);
            3'd2, 3'd5: r = (ones % 2 == 1);
            default:    r = (ones == n);
        endcase
        if (mode >= 3'd3 && mode <= 3'd5) r = ~r;
        return r;
    endfunction

    // A debounced bit flips once the last D synchronised samples all disagree with it.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int         n;
            logic [4:0] raw;
            logic [4:0] ndb;
            logic       all_mis;
            n   = (d == 0) ? 2 : 4;
            raw = (d == 0) ? {2'b00, btn, bus2.i_p_sw} : {btn, bus4.i_p_sw};
            if (rst) begin
                for (int k = 0; k < D + 2; k++) m_hist[d][k] <= '0;
                m_db[d]    <= '0;
                m_mode[d]  <= 3'd0;
                m_pulse[d] <= 1'b0;
                m_prev[d]  <= 1'b0;
                m_gate[d]  <= 1'b0;
            end else begin
                ndb = m_db[d];
                for (int i = 0; i <= n; i++) begin
                    all_mis = 1'b1;
                    for (int k = 1; k <= D; k++) begin
                        if (m_hist[d][k][i] == m_db[d][i]) all_mis = 1'b0;
                    end
                    if (all_mis) ndb[i] = ~m_db[d][i];
                end
                m_db[d]    <= ndb;
                m_gate[d]  <= gate_ref(m_db[d][3:0], n, m_mode[d]);
                m_mode[d]  <= m_pulse[d] ? ((m_mode[d] >= 3'd5) ? 3'd0 : m_mode[d] + 3'd1)
                                         : m_mode[d];
                m_pulse[d] <= m_db[d][n] & ~m_prev[d];
                m_prev[d]  <= m_db[d][n];
                m_hist[d][0] <= raw;
                for (int k = 1; k < D + 2; k++) m_hist[d][k] <= m_hist[d][k-1];
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_model();
        chk("model/in2",   {6'b0, bus2.o_p_led_in},   {6'b0, m_db[0][1:0]});
        chk("model/gate2", {7'b0, bus2.o_p_led_gate}, {7'b0, m_gate[0]});
        chk("model/mode2", {5'b0, bus2.o_p_led_mode}, {5'b0, m_mode[0]});
        chk("model/in4",   {4'b0, bus4.o_p_led_in},   {4'b0, m_db[1][3:0]});
        chk("model/gate4", {7'b0, bus4.o_p_led_gate}, {7'b0, m_gate[1]});
        chk("model/mode4", {5'b0, bus4.o_p_led_mode}, {5'b0, m_mode[1]});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cmp_model();
        end
    endtask

    task automatic press();
        btn = 1'b1;
        step(20);
        btn = 1'b0;
        step(20);
    endtask

    initial begin
        logic [5:0] exp_gate;
        exp_gate = 6'b000111;

        // Reset with switches already high.
        rst = 1'b1;
        btn = 1'b0;
        bus2.i_p_sw = 2'b11;
        bus4.i_p_sw = 4'b1111;
        @(negedge clk);
        chk("rst/in2",   {6'b0, bus2.o_p_led_in},   8'h00);
        chk("rst/gate2", {7'b0, bus2.o_p_led_gate}, 8'h00);
        chk("rst/mode2", {5'b0, bus2.o_p_led_mode}, 8'h00);
        step(2);
        rst = 1'b0;
        step(1);
        chk("post_rst/in2",   {6'b0, bus2.o_p_led_in},   8'h00);
        chk("post_rst/mode2", {5'b0, bus2.o_p_led_mode}, 8'h00);
        step(4);
        chk("rst_c5/in2",   {6'b0, bus2.o_p_led_in},   8'h00);
        step(1);
        chk("rst_c6/in2",   {6'b0, bus2.o_p_led_in},   8'h03);
        chk("rst_c6/gate2", {7'b0, bus2.o_p_led_gate}, 8'h00);
        chk("rst_c6/in4",   {4'b0, bus4.o_p_led_in},   8'h0f);
        step(1);
        chk("rst_c7/gate2", {7'b0, bus2.o_p_led_gate}, 8'h01);
        chk("rst_c7/gate4", {7'b0, bus4.o_p_led_gate}, 8'h01);

        // Glitch rejection: three-cycle pulse discarded, longer hold accepted.
        bus2.i_p_sw = 2'b00;
        step(10);
        bus2.i_p_sw = 2'b01;
        step(3);
        bus2.i_p_sw = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("glitch/in2",   {6'b0, bus2.o_p_led_in},   8'h00);
            chk("glitch/gate2", {7'b0, bus2.o_p_led_gate}, 8'h00);
        end
        bus2.i_p_sw = 2'b01;
        step(5);
        chk("hold_c5/in2", {6'b0, bus2.o_p_led_in}, 8'h00);
        step(1);
        chk("hold_c6/in2", {6'b0, bus2.o_p_led_in}, 8'h01);

        // Mode stepping with SW=01, exact latency and single advance per press.
        step(4);
        for (int p = 1; p <= 6; p++) begin
            btn = 1'b1;
            step(7);
            chk("press_c7/mode2", {5'b0, bus2.o_p_led_mode}, {5'b0, 3'((p - 1) % 6)});
            step(1);
            chk("press_c8/mode2", {5'b0, bus2.o_p_led_mode}, {5'b0, 3'(p % 6)});
            step(12);
            btn = 1'b0;
            step(20);
            chk("press_end/mode2", {5'b0, bus2.o_p_led_mode}, {5'b0, 3'(p % 6)});
            chk("press_end/mode4", {5'b0, bus4.o_p_led_mode}, {5'b0, 3'(p % 6)});
            chk("press_end/gate2", {7'b0, bus2.o_p_led_gate}, {7'b0, exp_gate[p-1]});
        end

        // Parity and inverted gates on the 4-input instance.
        bus4.i_p_sw = 4'b1011;
        press();
        press();
        chk("par/xor4", {7'b0, bus4.o_p_led_gate}, 8'h01);
        press();
        press();
        press();
        chk("par/xnor4", {7'b0, bus4.o_p_led_gate}, 8'h00);
        bus4.i_p_sw = 4'b1111;
        step(10);
        press();
        chk("ones/and4", {7'b0, bus4.o_p_led_gate}, 8'h01);
        press();
        press();
        press();
        chk("ones/nand4", {7'b0, bus4.o_p_led_gate}, 8'h00);
        press();
        chk("ones/nor4", {7'b0, bus4.o_p_led_gate}, 8'h00);

        // Reset part-way through a button debounce.
        btn = 1'b1;
        step(4);
        rst = 1'b1;
        btn = 1'b0;
        step(2);
        rst = 1'b0;
        step(20);
        chk("rst_mid/mode2", {5'b0, bus2.o_p_led_mode}, 8'h00);
        chk("rst_mid/mode4", {5'b0, bus4.o_p_led_mode}, 8'h00);

        // Switch change and button press launched together.
        bus2.i_p_sw = 2'b00;
        step(12);
        bus2.i_p_sw = 2'b11;
        btn = 1'b1;
        step(5);
        chk("sim_c5/in2", {6'b0, bus2.o_p_led_in}, 8'h00);
        step(1);
        chk("sim_c6/in2",   {6'b0, bus2.o_p_led_in},   8'h03);
        chk("sim_c6/gate2", {7'b0, bus2.o_p_led_gate}, 8'h00);
        step(1);
        chk("sim_c7/gate2", {7'b0, bus2.o_p_led_gate}, 8'h01);
        chk("sim_c7/mode2", {5'b0, bus2.o_p_led_mode}, 8'h00);
        step(1);
        chk("sim_c8/mode2", {5'b0, bus2.o_p_led_mode}, 8'h01);
        step(1);
        chk("sim_c9/gate2", {7'b0, bus2.o_p_led_gate}, 8'h01);
        btn = 1'b0;
        step(10);

        // Random stimulus with sparse changes so levels get a chance to settle.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) bus2.i_p_sw = 2'($urandom);
            if ($urandom_range(7) == 0) bus4.i_p_sw = 4'($urandom);
            if ($urandom_range(9) == 0) btn = ~btn;
            rst = ($urandom_range(199) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
